// File: rtl/imem_reader_pkg.sv
// imem_reader_pkg
//   Shared constants for the instruction-memory loader/reader: opcode
//   constants, register indices, ALU result codes and FSM state encoding.
//   Optional build macro used by the reader: IMEM_READER_PARITY_EN.
package imem_reader_pkg;

  localparam logic [6:0]  OPCODE_I = 7'b0010011;
  localparam logic [6:0]  OPCODE_R = 7'b0110011;
  localparam logic [31:0] JAL_HALT = 32'h0000_006F;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  localparam logic [4:0] REG_OP1 = 5'd9;
  localparam logic [4:0] REG_OP2 = 5'd10;
  localparam logic [4:0] REG_RES = 5'd11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_NOP = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CHECK,
    S_FIN
  } state_e;

  // {funct7, funct3} -> {valid, alu code}
  function automatic logic [3:0] alu_map(input logic [9:0] f7f3);
    case (f7f3)
      {7'h00, 3'b000}: alu_map = {1'b1, ALU_ADD};
      {7'h20, 3'b000}: alu_map = {1'b1, ALU_SUB};
      {7'h00, 3'b111}: alu_map = {1'b1, ALU_AND};
      {7'h00, 3'b110}: alu_map = {1'b1, ALU_OR};
      {7'h00, 3'b100}: alu_map = {1'b1, ALU_XOR};
      {7'h00, 3'b010}: alu_map = {1'b1, ALU_SLT};
      default:         alu_map = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/imem_word_decode.sv
// imem_word_decode
//   Combinational check/decode of one program word according to its
//   position in the 4-word program.
//   Ports:
//     word_i  [31:0] captured instruction word
//     idx_i   [1:0]  word position (0..3)
//     pass_o         word is well formed for its position
//     field_o [7:0]  immediate (words 0/1) or zero-extended ALU code (word 2)
//   Not affected by IMEM_READER_PARITY_EN (parity is checked by the reader).
module imem_word_decode
  import imem_reader_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  idx_i,
  output logic        pass_o,
  output logic [7:0]  field_o
);

  logic [3:0] alu_m;
  logic [4:0] rd_exp;

  always_comb begin
    pass_o  = 1'b0;
    field_o = '0;
    alu_m   = alu_map({word_i[31:25], word_i[14:12]});
    rd_exp  = (idx_i == 2'd0) ? REG_OP1 : REG_OP2;
    case (idx_i)
      2'd0, 2'd1: begin
        // addi rd, x0, imm with imm limited to 8 bits
        pass_o  = (word_i[6:0] == OPCODE_I) && (word_i[14:12] == 3'b000) &&
                  (word_i[19:15] == 5'd0) && (word_i[11:7] == rd_exp) &&
                  (word_i[31:28] == 4'h0);
        field_o = word_i[27:20];
      end
      2'd2: begin
        if (word_i == NOP) begin
          pass_o  = 1'b1;
          field_o = {5'd0, ALU_NOP};
        end else begin
          pass_o  = (word_i[6:0] == OPCODE_R) && (word_i[11:7] == REG_RES) &&
                    (word_i[19:15] == REG_OP1) && (word_i[24:20] == REG_OP2) &&
                    alu_m[3];
          field_o = {5'd0, alu_m[2:0]};
        end
      end
      default: pass_o = (word_i == JAL_HALT);
    endcase
  end

endmodule

// File: rtl/imem_reader.sv
// imem_reader
//   Reads a 4-word program from instruction memory, checks each word and
//   decodes two immediates and an ALU code. Stops at the first bad word.
//   Ports:
//     clk_i, rst_ni        clock, async active-low reset
//     start_i              one-cycle request (accepted only when idle)
//     imem_re_o/addr_o     read request, byte address BASE_ADDR+4*idx
//     imem_rdata_i         read data, valid RD_LAT cycles after imem_re_o
//     imem_rparity_i       even parity of imem_rdata_i (IMEM_READER_PARITY_EN only)
//     op1_o, op2_o         immediates of words 0 and 1
//     alu_op_o             ALU code of word 2
//     busy_o, done_o       in progress / one-cycle completion pulse
//     error_o, err_idx_o   program malformed, index of first failing word
//   Build option: define IMEM_READER_PARITY_EN to add the parity input/check.
module imem_reader
  import imem_reader_pkg::*;
#(
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        imem_re_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
`ifdef IMEM_READER_PARITY_EN
  input  logic        imem_rparity_i,
`endif
  output logic [7:0]  op1_o,
  output logic [7:0]  op2_o,
  output logic [2:0]  alu_op_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  err_idx_o
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_e      state_q;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  lat_q;
  logic [31:0] word_q;
  logic        re_q;
  logic [31:0] addr_q;
  logic [7:0]  op1_q, op2_q;
  logic [2:0]  alu_q;
  logic        busy_q, done_q, err_q;
  logic [1:0]  eidx_q;
  logic        dec_pass, pass_d;
  logic [7:0]  dec_field;

  imem_word_decode u_dec (
    .word_i  (word_q),
    .idx_i   (idx_q),
    .pass_o  (dec_pass),
    .field_o (dec_field)
  );

`ifdef IMEM_READER_PARITY_EN
  logic par_q;
  // a parity mismatch fails the word regardless of its contents
  assign pass_d = dec_pass && (par_q == ^word_q);
`else
  assign pass_d = dec_pass;
`endif

  assign idx_d = idx_q + 2'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lat_q   <= '0;
      word_q  <= '0;
      re_q    <= 1'b0;
      addr_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      alu_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      eidx_q  <= '0;
`ifdef IMEM_READER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            idx_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            alu_q   <= '0;
            err_q   <= 1'b0;
            eidx_q  <= '0;
            busy_q  <= 1'b1;
            re_q    <= 1'b1;
            addr_q  <= BASE_ADDR;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          re_q    <= 1'b0;
          addr_q  <= '0;
          lat_q   <= LAT_LAST;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_q == 2'd0) begin
            word_q  <= imem_rdata_i;
`ifdef IMEM_READER_PARITY_EN
            par_q   <= imem_rparity_i;
`endif
            state_q <= S_CHECK;
          end else begin
            lat_q <= lat_q - 2'd1;
          end
        end
        S_CHECK: begin
          if (pass_d) begin
            case (idx_q)
              2'd0:    op1_q <= dec_field;
              2'd1:    op2_q <= dec_field;
              2'd2:    alu_q <= dec_field[2:0];
              default: ;
            endcase
            if (idx_q == 2'd3) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_FIN;
            end else begin
              idx_q   <= idx_d;
              re_q    <= 1'b1;
              addr_q  <= BASE_ADDR + {28'd0, idx_d, 2'b00};
              state_q <= S_REQ;
            end
          end else begin
            err_q   <= 1'b1;
            eidx_q  <= idx_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_FIN;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_re_o   = re_q;
  assign imem_addr_o = addr_q;
  assign op1_o       = op1_q;
  assign op2_o       = op2_q;
  assign alu_op_o    = alu_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = err_q;
  assign err_idx_o   = eidx_q;

endmodule
